// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed seven-segment driver for a packed BCD word.
// Scans units/tens at CLK_DIV cycles per digit; segments and anodes are active-low.
module bcd_seg_scan #(
   parameter int unsigned CLK_DIV  = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bcd_in,
   input  logic       bcd_we,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       busy_tick
);

   localparam int unsigned CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [6:0]  SEG_OFF  = 7'h7F;
   localparam logic [6:0]  SEG_DASH = 7'h3F;

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_UNITS = 2'd1,
      S_TENS  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         hold_q, hold_d;
   logic [3:0]         shadow_q, shadow_d;
   logic [6:0]         seg_d;
   logic [1:0]         an_d;
   logic               busy_d;
   logic               term_c;
   logic               switch_c;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   assign term_c = (cnt_q == CNT_W'(CLK_DIV - 1));

   // State register: leaving S_OFF on the first edge after reset acts as a digit switch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_OFF;
         cnt_q     <= '0;
         hold_q    <= 8'h00;
         shadow_q  <= 4'h0;
         seg       <= SEG_OFF;
         an        <= 2'b11;
         busy_tick <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         shadow_q  <= shadow_d;
         seg       <= seg_d;
         an        <= an_d;
         busy_tick <= busy_d;
      end
   end

   // Next-state, shadow reload (write bypasses into the incoming digit) and output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hold_d   = bcd_we ? bcd_in : hold_q;
      shadow_d = shadow_q;
      switch_c = 1'b0;
      seg_d    = SEG_OFF;
      an_d     = 2'b11;
      busy_d   = 1'b0;

      case (state_q)
         S_OFF: begin
            state_d  = S_UNITS;
            cnt_d    = '0;
            switch_c = 1'b1;
         end
         S_UNITS: begin
            if (term_c) begin
               state_d  = S_TENS;
               cnt_d    = '0;
               switch_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_TENS: begin
            if (term_c) begin
               state_d  = S_UNITS;
               cnt_d    = '0;
               switch_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
         end
      endcase

      if (switch_c) begin
         shadow_d = (state_d == S_TENS) ? hold_d[7:4] : hold_d[3:0];
      end

      case (state_d)
         S_UNITS: begin
            an_d   = 2'b10;
            seg_d  = seg_decode(shadow_d);
            busy_d = switch_c;
         end
         S_TENS: begin
            an_d  = 2'b01;
            seg_d = (BLANK_LZ && (shadow_d == 4'h0)) ? SEG_OFF : seg_decode(shadow_d);
         end
         default: begin
            an_d  = 2'b11;
            seg_d = SEG_OFF;
         end
      endcase
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with CLK_DIV=4; a second instance runs with BLANK_LZ=0.
module tb_bcd_seg_scan;

   logic       clk;
   logic       rst_n;
   logic [7:0] bcd_in;
   logic       bcd_we;
   logic [6:0] seg, seg_nb;
   logic [1:0] an, an_nb;
   logic       busy_tick, busy_nb;

   int n_cmp;
   int n_bad;

   bcd_seg_scan #(.CLK_DIV(4), .BLANK_LZ(1'b1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bcd_in    (bcd_in),
      .bcd_we    (bcd_we),
      .seg       (seg),
      .an        (an),
      .busy_tick (busy_tick)
   );

   bcd_seg_scan #(.CLK_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
      .clk       (clk),
      .rst_n     (rst_n),
      .bcd_in    (bcd_in),
      .bcd_we    (bcd_we),
      .seg       (seg_nb),
      .an        (an_nb),
      .busy_tick (busy_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   // Capture a word on the next edge (one cycle consumed)
   task automatic write_bcd(input logic [7:0] v);
      bcd_in = v;
      bcd_we = 1'b1;
      next_cyc();
      bcd_we = 1'b0;
   endtask

   task automatic sync_frame();
      for (int i = 0; i < 16; i++) begin
         next_cyc();
         if (busy_tick) break;
      end
      check("frame_sync", 8'(busy_tick), 8'h01);
   endtask

   // Checks one full frame from its start sample; leaves us at the next frame start
   task automatic check_frame(input string tag, input logic [6:0] eu, input logic [6:0] et,
                              input logic [6:0] et_nb);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_busy"}, 8'(busy_tick), (i == 0) ? 8'h01 : 8'h00);
         check({tag, "_an"}, 8'(an), (i < 4) ? 8'h02 : 8'h01);
         check({tag, "_seg"}, 8'(seg), (i < 4) ? 8'(eu) : 8'(et));
         check({tag, "_seg_nb"}, 8'(seg_nb), (i < 4) ? 8'(eu) : 8'(et_nb));
         next_cyc();
      end
      check({tag, "_period"}, 8'(busy_tick), 8'h01);
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b0;
      bcd_in = 8'h00;
      bcd_we = 1'b0;

      repeat (3) next_cyc();
      check("rst_seg", 8'(seg), 8'h7F);
      check("rst_an", 8'(an), 8'h03);
      check("rst_busy", 8'(busy_tick), 8'h00);

      rst_n = 1'b1;
      next_cyc();
      check("rel_an", 8'(an), 8'h02);
      check("rel_seg", 8'(seg), 8'h40);
      check("rel_busy", 8'(busy_tick), 8'h01);

      write_bcd(8'h37);
      sync_frame();
      check_frame("scan37", 7'h78, 7'h30, 7'h30);

      write_bcd(8'h05);
      sync_frame();
      check_frame("blank05", 7'h12, 7'h7F, 7'h40);

      write_bcd(8'hA9);
      sync_frame();
      check_frame("badA9", 7'h10, 7'h3F, 7'h3F);

      write_bcd(8'h0C);
      sync_frame();
      check_frame("bad0C", 7'h3F, 7'h7F, 7'h40);

      // At frame start showing units of 0C; a mid-units write must not tear
      write_bcd(8'h12);
      for (int i = 1; i < 4; i++) begin
         check("tear_an", 8'(an), 8'h02);
         check("tear_seg", 8'(seg), 8'h3F);
         next_cyc();
      end
      for (int i = 4; i < 7; i++) begin
         check("tear_tens_an", 8'(an), 8'h01);
         check("tear_tens_seg", 8'(seg), 8'h79);
         next_cyc();
      end
      check("pre_term_seg", 8'(seg), 8'h79);
      // Write lands on the terminal-count edge: incoming units uses it directly
      write_bcd(8'h45);
      check("coll_busy", 8'(busy_tick), 8'h01);
      check("coll_an", 8'(an), 8'h02);
      check("coll_seg", 8'(seg), 8'h12);
      repeat (4) next_cyc();
      check("coll_tens_an", 8'(an), 8'h01);
      check("coll_tens_seg", 8'(seg), 8'h19);

      write_bcd(8'h99);
      sync_frame();
      repeat (5) next_cyc();
      check("pre_rst_an", 8'(an), 8'h01);
      check("pre_rst_seg", 8'(seg), 8'h10);
      rst_n = 1'b0;
      #2;
      check("mid_rst_seg", 8'(seg), 8'h7F);
      check("mid_rst_an", 8'(an), 8'h03);
      check("mid_rst_busy", 8'(busy_tick), 8'h00);
      next_cyc();
      check("mid_rst_hold_an", 8'(an), 8'h03);
      rst_n = 1'b1;
      next_cyc();
      check("post_rst_an", 8'(an), 8'h02);
      check("post_rst_seg", 8'(seg), 8'h40);
      check("post_rst_busy", 8'(busy_tick), 8'h01);
      repeat (4) next_cyc();
      check("post_rst_tens_an", 8'(an), 8'h01);
      check("post_rst_tens_seg", 8'(seg), 8'h7F);
      check("post_rst_tens_nb", 8'(seg_nb), 8'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Two-digit multiplexed seven-segment display driver that consumes the 8-bit packed BCD word produced by the binary-to-BCD stage (tens in [7:4], units in [3:0]). It holds the last written word, scans the two digits at a programmable rate, decodes each nibble to active-low segments and drives active-low digit anodes. It sits between the converter output and the board display pins.

## Interface

- CLK_DIV, 50000, clk cycles each digit stays lit; legal range 2..2^20
- BLANK_LZ, 1, 1 = blank tens digit when it is 0; 0 = always show it
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- bcd_in  in  8  packed BCD word {tens, units}
- bcd_we  in  1  write strobe; bcd_in captured on any clk edge where high
- seg  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  out  2  anode drive, active-low; an[0] = units, an[1] = tens
- busy_tick  out  1  one-cycle pulse at each frame start (units digit selected)

## Operation

- Holding register hold[7:0]: loads bcd_in when bcd_we=1; otherwise keeps value. Reset value 8'h00.
- New hold value is first displayed at the next digit switch; no mid-digit tearing: the digit being shown samples a shadow copy taken at its switch point.
- Divider cnt counts 0..CLK_DIV-1, wraps to 0. Terminal count (cnt=CLK_DIV-1) toggles sel (0 = units, 1 = tens) and reloads shadow nibble from hold.
- Decode, active-low gfedcba: 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10.
- Nibble 10..15 (invalid BCD): dash, seg=7'h3F.
- Leading-zero blank: sel=1, tens nibble=0, BLANK_LZ=1 → seg=7'h7F, an=2'b01 still asserted (constant current, no flicker). Invalid tens nibble is never blanked.
- Units digit is never blanked; value 00 shows "0" on units only when BLANK_LZ=1.
- busy_tick=1 on the cycle sel becomes 0 (after reset release, on the first cycle).

## Timing

- Reset (rst_n=0, immediate): cnt=0, sel=0, hold=8'h00, shadow=0, seg=7'h7F, an=2'b11, busy_tick=0.
- All outputs registered. First rising edge after rst_n deasserts: an=2'b10, seg=7'h40 (units "0"), busy_tick=1.
- Each digit lit exactly CLK_DIV cycles; frame = 2×CLK_DIV cycles; an toggles on the cycle after terminal count.
- bcd_we on the same edge as terminal count: new hold value is used by the incoming digit (write has priority, bypass into shadow).
- bcd_we held continuously: last value wins; no other effect.
- rst_n asserted mid-digit: outputs go to reset values asynchronously; scan restarts with units and hold=8'h00.
- an is never 2'b00; exactly one anode active whenever not in reset.

## Test plan

- Reset: CLK_DIV=4, rst_n low → seg=7'h7F, an=2'b11; release → next edge an=2'b10, seg=7'h40, busy_tick=1.
- Scan: write 8'h37 → units shows 7'h78 on an=2'b10 for 4 cycles, tens shows 7'h30 on an=2'b01 for 4 cycles, busy_tick period 8 cycles.
- Blanking: write 8'h05, BLANK_LZ=1 → tens phase seg=7'h7F an=2'b01, units seg=7'h12; BLANK_LZ=0 → tens seg=7'h40.
- Invalid BCD: write 8'hA9 → tens seg=7'h3F, units seg=7'h10; write 8'h0C → tens blanked, units 7'h3F.
- No tearing / collision: write 8'h12 mid-units phase → units remains previous value until switch; write on terminal-count edge → incoming digit shows new nibble.
- Mid-operation reset: assert rst_n during tens phase of 8'h99 → immediate reset values; after release display shows 00 pattern (units 7'h40, tens blank).
